vote_ballot_collector: RTL and testbench
========================================

Name: vote_ballot_collector

Overview:
Sequential front end for the 4-voter vote decision logic. It collects one ballot per voter over a valid/ready handshake and tracks the voting-window timeout. It then presents the assembled 4-bit ballot vector with a majority/tie decision on a held result handshake. It sits between the voter interfaces and downstream consumers of the win/tie decision.

Parameters:
- N_VOTERS, 4, number of voters; fixed at 4, with a 2-bit voter id.
- TIMEOUT_CYC, 16, cycles a session stays open in COLLECT before absent voters are forced to 0. Must be ≥1.
- CNT_W, 5, width of the timeout counter; requires 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- open_i  in  1  single-cycle pulse; starts a session (honoured only in IDLE)
- vote_valid  in  1  ballot offered
- vote_ready  out  1  ballot accepted when vote_valid && vote_ready
- vote_id  in  2  voter index 0..3
- vote_val  in  1  1 = yes, 0 = no
- dup_err  out  1  one-cycle pulse: handshaked ballot from a voter who already voted
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- ballot  out  4  bit i = voter i's vote; absent voters = 0
- yes_count  out  3  popcount of ballot, range 0..4
- win  out  1  yes_count >= 3
- tie  out  1  yes_count == 2
- timed_out  out  1  session closed by timeout rather than by all 4 voting
- busy  out  1  state != IDLE

Behaviour:
- Reset is asynchronous on falling rst_n. All outputs and internal registers go to 0; the state goes to IDLE.
- States and transitions:
  - IDLE: vote_ready=0. When open_i=1, clear ballot, the voted mask and the timer, then go to COLLECT next cycle.
  - COLLECT: vote_ready=1. On a handshake, with voted[vote_id]=0:
    - set ballot[vote_id]=vote_val and voted[vote_id]=1.
  - COLLECT, duplicate: a handshake with voted[vote_id]=1 leaves ballot unchanged and pulses dup_err on the next cycle.
  - COLLECT timer: increments every cycle spent in COLLECT.
  - COLLECT exit: go to DECIDE when voted becomes 4'b1111 (including the cycle the last ballot lands), or when timer == TIMEOUT_CYC-1.
  - COLLECT, simultaneous events: if the final ballot and the timeout occur in the same cycle, the ballot is accepted and timed_out=0.
  - DECIDE: one cycle. Register yes_count, win, tie and timed_out (set if voted != 4'b1111), then go to RESULT.
  - RESULT: result_valid=1. All result outputs are held stable until result_valid && result_ready, then return to IDLE. vote_ready=0.
- Latency:
  - open_i to vote_ready: 1 cycle.
  - Final accepted ballot to result_valid: 2 cycles.
- open_i outside IDLE is ignored. A session cannot restart until the result has been accepted.
- vote_valid while vote_ready=0 is not consumed; no error is raised.
- ballot, yes_count, win, tie and timed_out keep their last values in IDLE. They are cleared on the next open_i.
- win and tie are mutually exclusive; yes_count ∈ {0,1} gives win=0, tie=0.
- Reset asserted mid-session aborts immediately. No result is produced, and no dup_err pulse survives the reset.

Test Plan:
- Reset, then open_i. Voters 0..3 vote 1,1,0,1 on consecutive cycles → ballot=4'b1011, yes_count=3, win=1, tie=0, timed_out=0. result_valid rises 2 cycles after voter 3's ballot.
- Vote pattern 0,1,1,0 with result_ready held low for 5 cycles → ballot=4'b0110, tie=1, win=0. result_valid and all outputs stay stable until result_ready=1; the cycle after acceptance, busy=0.
- Voter 2 votes 1, then voter 2 votes 0 → dup_err pulses once, ballot[2] stays 1. The session completes normally once voters 0, 1 and 3 have voted.
- Only voters 0 and 1 vote yes with TIMEOUT_CYC=16 → session closes at timer=15, timed_out=1, ballot=4'b0011, tie=1.
- Final ballot arrives in the timeout cycle → ballot accepted, timed_out=0. An open_i pulsed during RESULT is ignored (busy unaffected, no new session).
- rst_n pulled low mid-COLLECT after 2 ballots → all outputs 0 asynchronously. A subsequent open_i starts a clean session with ballot=4'b0000.

Source files
------------

// File: rtl/vote_ballot_collector_if.sv
// Voter ballot / result handshake bundle for the 4-voter ballot collector.
// The master side drives sessions and ballots and consumes results; the slave side is the collector.
interface vote_ballot_collector_if;
    logic       open_i;
    logic       vote_valid;
    logic       vote_ready;
    logic [1:0] vote_id;
    logic       vote_val;
    logic       dup_err;
    logic       result_valid;
    logic       result_ready;
    logic [3:0] ballot;
    logic [2:0] yes_count;
    logic       win;
    logic       tie;
    logic       timed_out;
    logic       busy;

    modport master (
        output open_i, vote_valid, vote_id, vote_val, result_ready,
        input  vote_ready, dup_err, result_valid, ballot, yes_count,
               win, tie, timed_out, busy
    );

    modport slave (
        input  open_i, vote_valid, vote_id, vote_val, result_ready,
        output vote_ready, dup_err, result_valid, ballot, yes_count,
               win, tie, timed_out, busy
    );
endinterface

// File: rtl/vote_ballot_collector.sv
// Collects one ballot per voter within a timed window, then holds the assembled
// ballot with its majority/tie decision on a result handshake until it is accepted.
module vote_ballot_collector #(
    parameter int N_VOTERS    = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    vote_ballot_collector_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DECIDE  = 2'd2,
        S_RESULT  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [N_VOTERS-1:0] r_ballot;
    logic [N_VOTERS-1:0] r_voted;
    logic [CNT_W-1:0]    r_timer;
    logic                r_dup_err;
    logic [2:0]          r_yes_count;
    logic                r_win;
    logic                r_tie;
    logic                r_timed_out;

    logic                w_hs;
    logic                w_new_vote;
    logic                w_dup;
    logic [N_VOTERS-1:0] w_voted_nxt;
    logic                w_all_voted;
    logic                w_timeout;
    logic [2:0]          w_yes;

    function automatic logic [2:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + 3'(v[i]);
        end
        return c;
    endfunction

    assign w_hs        = bus.vote_valid && (r_state == S_COLLECT);
    assign w_dup       = w_hs &&  r_voted[bus.vote_id];
    assign w_new_vote  = w_hs && !r_voted[bus.vote_id];
    assign w_voted_nxt = r_voted | (w_new_vote ? (N_VOTERS'(1) << bus.vote_id) : '0);
    // The mask including this cycle's ballot wins over the timeout when both coincide.
    assign w_all_voted = &w_voted_nxt;
    assign w_timeout   = (r_timer == CNT_W'(TIMEOUT_CYC - 1));
    assign w_yes       = popcount(r_ballot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.open_i)                w_next = S_COLLECT;
            S_COLLECT: if (w_all_voted || w_timeout)  w_next = S_DECIDE;
            S_DECIDE:                                 w_next = S_RESULT;
            S_RESULT:  if (bus.result_ready)          w_next = S_IDLE;
            default:                                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ballot    <= '0;
            r_voted     <= '0;
            r_timer     <= '0;
            r_dup_err   <= 1'b0;
            r_yes_count <= 3'd0;
            r_win       <= 1'b0;
            r_tie       <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            r_dup_err <= w_dup;
            case (r_state)
                S_IDLE: begin
                    // Results persist in IDLE and are only wiped by the next session.
                    if (bus.open_i) begin
                        r_ballot    <= '0;
                        r_voted     <= '0;
                        r_timer     <= '0;
                        r_yes_count <= 3'd0;
                        r_win       <= 1'b0;
                        r_tie       <= 1'b0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    r_timer <= r_timer + CNT_W'(1);
                    if (w_new_vote) begin
                        r_ballot[bus.vote_id] <= bus.vote_val;
                        r_voted               <= w_voted_nxt;
                    end
                end
                S_DECIDE: begin
                    r_yes_count <= w_yes;
                    r_win       <= (w_yes >= 3'd3);
                    r_tie       <= (w_yes == 3'd2);
                    r_timed_out <= ~(&r_voted);
                end
                default: ;
            endcase
        end
    end

    assign bus.vote_ready   = (r_state == S_COLLECT);
    assign bus.result_valid = (r_state == S_RESULT);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.dup_err      = r_dup_err;
    assign bus.ballot       = r_ballot;
    assign bus.yes_count    = r_yes_count;
    assign bus.win          = r_win;
    assign bus.tie          = r_tie;
    assign bus.timed_out    = r_timed_out;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector: table of full sessions plus
// hand sequences for duplicates, timeout, open during RESULT and mid-session reset.
module tb_vote_ballot_collector;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    vote_ballot_collector_if vif ();

    vote_ballot_collector #(
        .N_VOTERS    (4),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id [4];
        logic       val [4];
        int         hold;
        logic [3:0] exp_ballot;
        logic [2:0] exp_yes;
        logic       exp_win;
        logic       exp_tie;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        vif.open_i = 1'b1;
        tick();
        vif.open_i = 1'b0;
    endtask

    task automatic vote(input logic [1:0] id, input logic val);
        vif.vote_valid = 1'b1;
        vif.vote_id    = id;
        vif.vote_val   = val;
        tick();
        vif.vote_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] b, input logic [2:0] y,
                                input logic w, input logic t, input logic to);
        chk({tag, ".result_valid"}, 32'(vif.result_valid), 32'd1);
        chk({tag, ".ballot"},       32'(vif.ballot),       32'(b));
        chk({tag, ".yes_count"},    32'(vif.yes_count),    32'(y));
        chk({tag, ".win"},          32'(vif.win),          32'(w));
        chk({tag, ".tie"},          32'(vif.tie),          32'(t));
        chk({tag, ".timed_out"},    32'(vif.timed_out),    32'(to));
    endtask

    task automatic accept(input string tag);
        vif.result_ready = 1'b1;
        tick();
        vif.result_ready = 1'b0;
        chk({tag, ".busy_after_accept"},  32'(vif.busy),         32'd0);
        chk({tag, ".rv_after_accept"},    32'(vif.result_valid), 32'd0);
    endtask

    task automatic set_vec(input int k, input logic [1:0] i0, input logic v0,
                           input logic [1:0] i1, input logic v1,
                           input logic [1:0] i2, input logic v2,
                           input logic [1:0] i3, input logic v3,
                           input int hold, input logic [3:0] b, input logic [2:0] y,
                           input logic w, input logic t);
        vecs[k].id[0] = i0; vecs[k].val[0] = v0;
        vecs[k].id[1] = i1; vecs[k].val[1] = v1;
        vecs[k].id[2] = i2; vecs[k].val[2] = v2;
        vecs[k].id[3] = i3; vecs[k].val[3] = v3;
        vecs[k].hold       = hold;
        vecs[k].exp_ballot = b;
        vecs[k].exp_yes    = y;
        vecs[k].exp_win    = w;
        vecs[k].exp_tie    = t;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ballot"},       32'(vif.ballot),       32'd0);
        chk({tag, ".yes_count"},    32'(vif.yes_count),    32'd0);
        chk({tag, ".win"},          32'(vif.win),          32'd0);
        chk({tag, ".tie"},          32'(vif.tie),          32'd0);
        chk({tag, ".timed_out"},    32'(vif.timed_out),    32'd0);
        chk({tag, ".busy"},         32'(vif.busy),         32'd0);
        chk({tag, ".vote_ready"},   32'(vif.vote_ready),   32'd0);
        chk({tag, ".result_valid"}, 32'(vif.result_valid), 32'd0);
        chk({tag, ".dup_err"},      32'(vif.dup_err),      32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n            = 1'b0;
        vif.open_i       = 1'b0;
        vif.vote_valid   = 1'b0;
        vif.vote_id      = 2'd0;
        vif.vote_val     = 1'b0;
        vif.result_ready = 1'b0;

        //      ids/vals in presentation order                 hold ballot   yes   win   tie
        set_vec(0, 2'd0,1'b1, 2'd1,1'b1, 2'd2,1'b0, 2'd3,1'b1, 0, 4'b1011, 3'd3, 1'b1, 1'b0);
        set_vec(1, 2'd0,1'b0, 2'd1,1'b1, 2'd2,1'b1, 2'd3,1'b0, 5, 4'b0110, 3'd2, 1'b0, 1'b1);
        set_vec(2, 2'd3,1'b1, 2'd2,1'b1, 2'd1,1'b1, 2'd0,1'b1, 1, 4'b1111, 3'd4, 1'b1, 1'b0);
        set_vec(3, 2'd2,1'b0, 2'd0,1'b0, 2'd3,1'b0, 2'd1,1'b0, 0, 4'b0000, 3'd0, 1'b0, 1'b0);
        set_vec(4, 2'd1,1'b1, 2'd3,1'b0, 2'd0,1'b0, 2'd2,1'b0, 2, 4'b0010, 3'd1, 1'b0, 1'b0);
        set_vec(5, 2'd3,1'b1, 2'd0,1'b0, 2'd2,1'b0, 2'd1,1'b1, 0, 4'b1010, 3'd2, 1'b0, 1'b1);

        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full sessions from the table
        for (int k = 0; k < 6; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            open_session();
            chk({tag, ".vote_ready"}, 32'(vif.vote_ready), 32'd1);
            chk({tag, ".cleared"},    32'(vif.ballot),     32'd0);
            for (int j = 0; j < 4; j++) vote(vecs[k].id[j], vecs[k].val[j]);
            chk({tag, ".rv_decide"},  32'(vif.result_valid), 32'd0);
            chk({tag, ".ready_off"},  32'(vif.vote_ready),   32'd0);
            tick();
            check_result(tag, vecs[k].exp_ballot, vecs[k].exp_yes, vecs[k].exp_win, vecs[k].exp_tie, 1'b0);
            for (int h = 0; h < vecs[k].hold; h++) begin
                tick();
                chk({tag, ".hold_rv"},  32'(vif.result_valid), 32'd1);
                chk({tag, ".hold_b"},   32'(vif.ballot),       32'(vecs[k].exp_ballot));
                chk({tag, ".hold_tie"}, 32'(vif.tie),          32'(vecs[k].exp_tie));
            end
            accept(tag);
            chk({tag, ".idle_ballot"}, 32'(vif.ballot),    32'(vecs[k].exp_ballot));
            chk({tag, ".idle_yes"},    32'(vif.yes_count), 32'(vecs[k].exp_yes));
        end

        // Duplicate ballot from voter 2
        open_session();
        vote(2'd2, 1'b1);
        chk("dup.no_err_first", 32'(vif.dup_err), 32'd0);
        vote(2'd2, 1'b0);
        chk("dup.pulse",  32'(vif.dup_err), 32'd1);
        chk("dup.keep",   32'(vif.ballot),  32'b0100);
        chk("dup.busy",   32'(vif.vote_ready), 32'd1);
        vote(2'd0, 1'b0);
        chk("dup.pulse_end", 32'(vif.dup_err), 32'd0);
        vote(2'd1, 1'b0);
        vote(2'd3, 1'b1);
        tick();
        check_result("dup", 4'b1100, 3'd2, 1'b0, 1'b1, 1'b0);
        accept("dup");

        // Timeout with only voters 0 and 1 voting yes
        open_session();
        vote(2'd0, 1'b1);
        vote(2'd1, 1'b1);
        repeat (13) tick();
        chk("tmo.still_open", 32'(vif.vote_ready), 32'd1);
        tick();
        chk("tmo.closed",     32'(vif.vote_ready),   32'd0);
        chk("tmo.rv_decide",  32'(vif.result_valid), 32'd0);
        tick();
        check_result("tmo", 4'b0011, 3'd2, 1'b0, 1'b1, 1'b1);
        accept("tmo");

        // Final ballot lands in the timeout cycle; open_i during RESULT is ignored
        open_session();
        vote(2'd0, 1'b1);
        vote(2'd1, 1'b0);
        vote(2'd2, 1'b1);
        repeat (12) tick();
        chk("edge.open", 32'(vif.vote_ready), 32'd1);
        vote(2'd3, 1'b1);
        chk("edge.rv_decide", 32'(vif.result_valid), 32'd0);
        tick();
        check_result("edge", 4'b1101, 3'd3, 1'b1, 1'b0, 1'b0);
        open_session();
        chk("edge.open_ignored_rv",   32'(vif.result_valid), 32'd1);
        chk("edge.open_ignored_busy", 32'(vif.busy),         32'd1);
        accept("edge");
        tick();
        chk("edge.no_restart", 32'(vif.busy), 32'd0);
        vote(2'd1, 1'b1);
        chk("idle.vote_ignored", 32'(vif.ballot),  32'b1101);
        chk("idle.no_dup",       32'(vif.dup_err), 32'd0);

        // Asynchronous reset in the middle of COLLECT, with a dup pulse pending
        open_session();
        vote(2'd0, 1'b1);
        vote(2'd1, 1'b1);
        vote(2'd1, 1'b0);
        chk("rst.pre_dup",    32'(vif.dup_err), 32'd1);
        chk("rst.pre_ballot", 32'(vif.ballot),  32'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.async");
        #3;
        rst_n = 1'b1;
        tick();
        check_all_zero("rst.after");
        open_session();
        chk("rst.clean_ballot", 32'(vif.ballot),     32'd0);
        chk("rst.clean_ready",  32'(vif.vote_ready), 32'd1);
        vote(2'd0, 1'b0);
        vote(2'd1, 1'b1);
        vote(2'd2, 1'b0);
        vote(2'd3, 1'b0);
        tick();
        check_result("rst.session", 4'b0010, 3'd1, 1'b0, 1'b0, 1'b0);
        accept("rst.session");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
